scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
//  Scan-chain master for chains of scan flops (te/ti/cp scan-enable flops, cp sampled as an enable on sys_clk).
//  Per run: shifts a parallel pattern into the chain, fires one functional capture pulse, then shifts the captured response out.
//  Returns the response as a parallel word.
//  Sits between the test/debug register block and the tail of any scan chain in the design.
// PARAMETERS
//  CHAIN_LEN  32  number of flops in the chain (>=2)
//  CP_DIV     4   sys_clk cycles per cp period (>=2); cp is high for exactly 1 cycle per period
//  CNT_W      6   counter width, >= clog2(CHAIN_LEN+1)
// PORTS
//  sys_clk   in   1          system clock; all state and the chain flops update on its rising edge
//  rst       in   1          synchronous, active-high reset
//  start     in   1          start a run; sampled in IDLE only
//  capture   in   1          sampled with start; 1 = shift-in, capture, shift-out; 0 = shift-in only, no capture or shift-out
//  pattern   in   CHAIN_LEN  stimulus, latched on start; bit CHAIN_LEN-1 is shifted first (ends at chain tail)
//  busy      out  1          high from the cycle after start accepted until done
//  done      out  1          1-cycle pulse at end of run
//  response  out  CHAIN_LEN  captured chain contents; bit CHAIN_LEN-1 = tail flop; valid from done until next start
//  cp        out  1          chain clock-enable pulse
//  te        out  1          chain scan-enable (1 = shift, 0 = functional capture)
//  ti        out  1          serial data into chain head
//  so        in   1          serial data from chain tail (q of last flop)
// BEHAVIOUR
//  Reset: state=IDLE, cp=0, te=0, ti=0, busy=0, done=0, response=0, counters=0; effective the edge after rst is sampled high.
//  Reset mid-run: same values; no further cp pulses; chain contents are left as-is.
//  Tick: a divider counts 0..CP_DIV-1 while state != IDLE; cp=1 only when the count is CP_DIV-1. The divider is cleared on entry to each state.
//  te/ti change only in cycles where cp=0, never on the cp edge.
//  te is valid at least CP_DIV-1 cycles before the first pulse of each state.
//  FSM:
//   IDLE:   start=1 -> latch pattern/capture, te<=1, ti<=pattern[CHAIN_LEN-1], busy<=1 -> SHIFT_IN.
//           start while busy is ignored.
//   SHIFT_IN: CHAIN_LEN cp pulses. After pulse k (k=0..), ti<=pattern[CHAIN_LEN-2-k].
//           After the last pulse: if capture -> te<=0, ti<=0 -> CAPTURE; else -> FINISH.
//   CAPTURE: exactly 1 cp pulse with te=0; then te<=1, ti<=0 -> SHIFT_OUT.
//   SHIFT_OUT: CHAIN_LEN cp pulses, ti=0.
//           On each pulse cycle, so is sampled (pre-shift value) into response: response<={response[CHAIN_LEN-2:0],so}.
//           After the last pulse -> FINISH.
//   FINISH: te<=0, busy<=0, done<=1 for 1 cycle -> IDLE.
//  In shift-in-only mode, response is not modified.
//  Latency:
//   capture=1: (2*CHAIN_LEN+1)*CP_DIV + 2 cycles from start to done.
//   capture=0: CHAIN_LEN*CP_DIV + 2 cycles from start to done.
//  Bit counter saturates at CHAIN_LEN; no wrap is possible.
//  start and rst in the same cycle: rst wins.
//  done and a new start in the same cycle: start ignored (state not yet IDLE).
// STRUCTURE
//  Shared package scan_pkg: state encoding (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH), ST_W, and the CP_DIV minimum check.
//  Sub-module scan_tick: CP_DIV pulse divider with synchronous clear. Ports: sys_clk, rst, clr, en, tick.
//  Top level holds the FSM, the pattern and response shift registers, and the bit counter.
// TESTING (CHAIN_LEN=8, CP_DIV=2, DUT driving 8 chained scan flops; capture data d = ~q of each flop)
//  1. rst=1 for 2 cycles mid-SHIFT_OUT -> next edge: cp=0, te=0, busy=0, done=0, response=0; no cp for 10 further cycles.
//  2. start, capture=0, pattern=8'hA5 -> 8 cp pulses with te=1; chain q[7:0]=A5; done at cycle 18; response unchanged.
//  3. Preload chain A5, then start, capture=1, pattern=8'h3C -> chain=3C; one te=0 pulse flips chain to C3; response=8'hC3.
//     done at cycle 36; chain reads 00 afterwards.
//  4. start held high through the run -> exactly one run; start pulses during busy are ignored; busy is high for exactly 1 run.
//  5. Check on every cycle: te and ti never change on a cycle with cp=1, and cp is never high on two consecutive cycles.
//  6. rst and start in the same cycle -> stays IDLE, busy=0.
//     Then CHAIN_LEN=2, CP_DIV=3, capture=1, pattern=2'b10 -> response=2'b01; done at cycle 17.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain master: FSM state encoding and
// parameter sanity helpers used by scan_chain_ctrl and scan_tick.
// Latency: n/a (package). Backpressure: n/a.
package scan_pkg;

  localparam int ST_W          = 3;
  localparam int CP_DIV_MIN    = 2;
  localparam int CHAIN_LEN_MIN = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  // A divider of 1 would put cp high every cycle, so te/ti could never
  // move on a cycle with cp low.
  function automatic logic cp_div_ok(input int div);
    return div >= CP_DIV_MIN;
  endfunction

  // The bit counter must be able to hold CHAIN_LEN itself (saturation value).
  function automatic logic cnt_w_ok(input int chain_len, input int cnt_w);
    return (chain_len >= CHAIN_LEN_MIN) && (cnt_w >= $clog2(chain_len + 1));
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Purpose: CP_DIV divider producing a 1-cycle tick every CP_DIV enabled cycles.
// Latency: tick is a decode of the registered count (same cycle as count==CP_DIV-1).
// Backpressure: none; clr holds the count at zero, en freezes it when low.
//
// Ports:
//   sys_clk  in   system clock
//   rst      in   synchronous active-high reset
//   clr      in   synchronous clear of the count (wins over en)
//   en       in   count enable
//   tick     out  high for the single cycle in which the count is CP_DIV-1
module scan_tick
  import scan_pkg::*;
#(
  parameter int CP_DIV = 4
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (CP_DIV > 2) ? $clog2(CP_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CP_DIV - 1);

  logic [DW-1:0] r_cnt;

  if (!cp_div_ok(CP_DIV)) begin : g_bad_div
    $error("scan_tick: CP_DIV must be at least 2");
  end

  always_ff @(posedge sys_clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + DW'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Purpose: scan-chain master; shift a pattern in, optionally capture once and shift the response out.
// Latency: capture=1 -> (2*CHAIN_LEN+1)*CP_DIV+2 cycles start->done; capture=0 -> CHAIN_LEN*CP_DIV+2.
// Backpressure: none; start is only accepted in IDLE, and is ignored while busy or during done.
//
// Ports:
//   sys_clk   in   system clock (chain flops use cp as an enable on this clock)
//   rst       in   synchronous active-high reset
//   start     in   begin a run (sampled in IDLE only)
//   capture   in   1 = shift-in, capture, shift-out; 0 = shift-in only
//   pattern   in   stimulus, MSB shifted first so it lands in the tail flop
//   busy      out  high from the cycle after start is accepted until done
//   done      out  one-cycle end-of-run pulse
//   response  out  captured chain contents, MSB = tail flop
//   cp        out  chain clock-enable pulse
//   te        out  chain scan-enable (1 = shift, 0 = capture)
//   ti        out  serial data into the chain head
//   so        in   serial data from the chain tail
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CP_DIV    = 4,
  parameter int CNT_W     = 6
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 capture,
  input  logic [CHAIN_LEN-1:0] pattern,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 cp,
  output logic                 te,
  output logic                 ti,
  input  logic                 so
);

  if (!cnt_w_ok(CHAIN_LEN, CNT_W)) begin : g_bad_cnt
    $error("scan_chain_ctrl: CHAIN_LEN must be >= 2 and CNT_W >= clog2(CHAIN_LEN+1)");
  end

  state_t               r_state;
  logic [CHAIN_LEN-1:0] r_pat;   // bits still to be driven on ti, next one at MSB
  logic [CHAIN_LEN-1:0] r_resp;
  logic [CNT_W-1:0]     r_bit;
  logic                 r_cap;
  logic                 r_te;
  logic                 r_ti;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tick;
  logic                 w_last_bit;
  logic                 w_leave;
  logic                 w_clr;
  logic                 w_en;
  logic [CNT_W-1:0]     w_bit_inc;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_SAT  = CNT_W'(CHAIN_LEN);

  assign w_last_bit = (r_bit == BIT_LAST);
  assign w_bit_inc  = (r_bit < BIT_SAT) ? r_bit + CNT_W'(1) : r_bit;

  // A pulse that ends a state: the count wraps to zero on that edge anyway,
  // the explicit clear just makes "fresh count on every state entry" obvious.
  assign w_leave = w_tick &&
                   ((r_state == ST_CAPTURE) ||
                    (((r_state == ST_SHIFT_IN) || (r_state == ST_SHIFT_OUT)) && w_last_bit));

  // FINISH is held clear so a short divider can never fire cp during the
  // two-cycle wind-down.
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_FINISH) || w_leave;
  assign w_en  = (r_state != ST_IDLE);

  scan_tick #(
    .CP_DIV (CP_DIV)
  ) u_tick (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (w_clr),
    .en      (w_en),
    .tick    (w_tick)
  );

  // te/ti only ever update on the edge that closes a pulse cycle (or on
  // start/finish, when cp is low), so they are stable whenever cp is high.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_resp  <= '0;
      r_bit   <= '0;
      r_cap   <= 1'b0;
      r_te    <= 1'b0;
      r_ti    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pat   <= {pattern[CHAIN_LEN-2:0], 1'b0};
            r_cap   <= capture;
            r_te    <= 1'b1;
            r_ti    <= pattern[CHAIN_LEN-1];
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_state <= ST_SHIFT_IN;
          end
        end

        ST_SHIFT_IN: begin
          if (w_tick) begin
            if (w_last_bit) begin
              r_bit <= '0;
              if (r_cap) begin
                r_te    <= 1'b0;
                r_ti    <= 1'b0;
                r_state <= ST_CAPTURE;
              end else begin
                r_state <= ST_FINISH;
              end
            end else begin
              r_bit <= w_bit_inc;
              r_ti  <= r_pat[CHAIN_LEN-1];
              r_pat <= {r_pat[CHAIN_LEN-2:0], 1'b0};
            end
          end
        end

        ST_CAPTURE: begin
          if (w_tick) begin
            r_te    <= 1'b1;
            r_ti    <= 1'b0;
            r_state <= ST_SHIFT_OUT;
          end
        end

        ST_SHIFT_OUT: begin
          if (w_tick) begin
            // so is the tail flop before this pulse shifts it away.
            r_resp <= {r_resp[CHAIN_LEN-2:0], so};
            if (w_last_bit) begin
              r_bit   <= '0;
              r_state <= ST_FINISH;
            end else begin
              r_bit <= w_bit_inc;
            end
          end
        end

        ST_FINISH: begin
          // Two cycles: the first raises done, the second (done high) returns
          // to IDLE, so a start coinciding with done is not seen in IDLE.
          if (!r_done) begin
            r_te   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cp       = w_tick;
  assign te       = r_te;
  assign ti       = r_ti;
  assign busy     = r_busy;
  assign done     = r_done;
  assign response = r_resp;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop chain (CP_DIV=2) and a 2-flop chain
// (CP_DIV=3), each modelled with capture data d = ~q.
// Expected results are queued at issue time and checked when done appears.
module tb_scan_chain_ctrl;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst = 1'b1;

  // 8-bit chain instance
  logic       start1 = 1'b0, cap1 = 1'b0;
  logic [7:0] pat1 = '0;
  logic       busy1, done1, cp1, te1, ti1, so1;
  logic [7:0] resp1;
  logic [7:0] chain1 = '0;

  // 2-bit chain instance
  logic       start2 = 1'b0, cap2 = 1'b0;
  logic [1:0] pat2 = '0;
  logic       busy2, done2, cp2, te2, ti2, so2;
  logic [1:0] resp2;
  logic [1:0] chain2 = '0;

  scan_chain_ctrl #(.CHAIN_LEN(8), .CP_DIV(2), .CNT_W(4)) u_dut1 (
    .sys_clk(sys_clk), .rst(rst), .start(start1), .capture(cap1), .pattern(pat1),
    .busy(busy1), .done(done1), .response(resp1), .cp(cp1), .te(te1), .ti(ti1), .so(so1)
  );

  scan_chain_ctrl #(.CHAIN_LEN(2), .CP_DIV(3), .CNT_W(2)) u_dut2 (
    .sys_clk(sys_clk), .rst(rst), .start(start2), .capture(cap2), .pattern(pat2),
    .busy(busy2), .done(done2), .response(resp2), .cp(cp2), .te(te2), .ti(ti2), .so(so2)
  );

  // Scan flop chains: q[0] is the head (fed by ti), q[N-1] the tail (so).
  always @(posedge sys_clk) begin
    if (cp1 === 1'b1) chain1 <= te1 ? {chain1[6:0], ti1} : ~chain1;
    if (cp2 === 1'b1) chain2 <= te2 ? {chain2[0], ti2} : ~chain2;
  end
  assign so1 = chain1[7];
  assign so2 = chain2[1];

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] resp;
    logic [7:0] chain;
    int         lat;
    int         issue;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int done_cnt1 = 0;
  int done_cnt2 = 0;

  // Scoreboard monitors
  always @(negedge sys_clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        chk("dut1_response", 32'(resp1), 32'(e.resp));
        chk("dut1_chain", 32'(chain1), 32'(e.chain));
        chk("dut1_latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  always @(negedge sys_clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      done_cnt2++;
      if (q2.size() == 0) begin
        chk("dut2_unexpected_done", 32'(q2.size()), 32'd1);
      end else begin
        e = q2.pop_front();
        chk("dut2_response", 32'(resp2), 32'(e.resp[1:0]));
        chk("dut2_chain", 32'(chain2), 32'(e.chain[1:0]));
        chk("dut2_latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  // Chain-protocol checker and activity counters
  bit   pchk = 1'b0;
  logic pcp1 = 1'b0, pte1 = 1'b0, pti1 = 1'b0;
  logic pcp2 = 1'b0, pte2 = 1'b0, pti2 = 1'b0;
  logic pbusy1 = 1'b0;
  int   cp_cnt1 = 0, te0_cnt1 = 0, busy_cyc1 = 0, busy_rise1 = 0;

  always @(negedge sys_clk) begin
    if (pchk) begin
      if (cp1 === 1'b1) begin
        chk("dut1_cp_back_to_back", 32'(pcp1), 32'd0);
        chk("dut1_te_moved_on_cp", 32'(te1), 32'(pte1));
        chk("dut1_ti_moved_on_cp", 32'(ti1), 32'(pti1));
        cp_cnt1++;
        if (te1 === 1'b0) te0_cnt1++;
      end
      if (cp2 === 1'b1) begin
        chk("dut2_cp_back_to_back", 32'(pcp2), 32'd0);
        chk("dut2_te_moved_on_cp", 32'(te2), 32'(pte2));
        chk("dut2_ti_moved_on_cp", 32'(ti2), 32'(pti2));
      end
      if (busy1 === 1'b1) busy_cyc1++;
      if (busy1 === 1'b1 && pbusy1 === 1'b0) busy_rise1++;
    end
    pcp1 = cp1; pte1 = te1; pti1 = ti1;
    pcp2 = cp2; pte2 = te2; pti2 = ti2;
    pbusy1 = busy1;
  end

  task automatic run1(input logic c, input logic [7:0] p, input logic [7:0] er,
                      input logic [7:0] ec, input int lat, input bit hold);
    exp_t e;
    bit got;
    got = 1'b0;
    @(negedge sys_clk);
    start1 = 1'b1; cap1 = c; pat1 = p;
    e.resp = er; e.chain = ec; e.lat = lat; e.issue = cyc;
    q1.push_back(e);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge sys_clk);
      if (!hold) start1 = 1'b0;
      got = (done1 === 1'b1);
    end
    start1 = 1'b0;
    if (!got) chk("dut1_timeout", 32'(done1), 32'd1);
    @(negedge sys_clk);
  endtask

  task automatic run2(input logic c, input logic [1:0] p, input logic [1:0] er,
                      input logic [1:0] ec, input int lat);
    exp_t e;
    bit got;
    got = 1'b0;
    @(negedge sys_clk);
    start2 = 1'b1; cap2 = c; pat2 = p;
    e.resp = {6'd0, er}; e.chain = {6'd0, ec}; e.lat = lat; e.issue = cyc;
    q2.push_back(e);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge sys_clk);
      start2 = 1'b0;
      got = (done2 === 1'b1);
    end
    if (!got) chk("dut2_timeout", 32'(done2), 32'd1);
    @(negedge sys_clk);
  endtask

  initial begin : global_timeout
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] snap;
    int d0;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_cp", 32'(cp1), 32'd0);
    chk("rst_te", 32'(te1), 32'd0);
    chk("rst_ti", 32'(ti1), 32'd0);
    chk("rst_response", 32'(resp1), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_response2", 32'(resp2), 32'd0);
    rst = 1'b0;
    pchk = 1'b1;

    // Shift-in only: chain takes the pattern, response untouched
    cp_cnt1 = 0; te0_cnt1 = 0;
    run1(1'b0, 8'hA5, 8'h00, 8'hA5, 18, 1'b0);
    chk("shift_only_cp_pulses", 32'(cp_cnt1), 32'd8);
    chk("shift_only_te0_pulses", 32'(te0_cnt1), 32'd0);

    // Full run over preloaded A5: 3C in, captured to C3, zeros shifted in
    cp_cnt1 = 0; te0_cnt1 = 0;
    run1(1'b1, 8'h3C, 8'hC3, 8'h00, 36, 1'b0);
    chk("capture_cp_pulses", 32'(cp_cnt1), 32'd17);
    chk("capture_te0_pulses", 32'(te0_cnt1), 32'd1);

    // Shift-in only leaves the previous response in place
    run1(1'b0, 8'h5A, 8'hC3, 8'h5A, 18, 1'b0);

    // start held high through the whole run, including the done cycle
    busy_cyc1 = 0; busy_rise1 = 0;
    d0 = done_cnt1;
    run1(1'b1, 8'h0F, 8'hF0, 8'h00, 36, 1'b1);
    repeat (4) @(negedge sys_clk);
    chk("held_start_busy_rises", 32'(busy_rise1), 32'd1);
    chk("held_start_busy_cycles", 32'(busy_cyc1), 32'd35);
    chk("held_start_done_count", 32'(done_cnt1 - d0), 32'd1);
    chk("held_start_idle_after", 32'(busy1), 32'd0);

    // Reset in the middle of SHIFT_OUT
    @(negedge sys_clk);
    start1 = 1'b1; cap1 = 1'b1; pat1 = 8'h81;
    @(negedge sys_clk);
    start1 = 1'b0;
    repeat (24) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    snap = chain1;
    chk("midrun_rst_cp", 32'(cp1), 32'd0);
    chk("midrun_rst_te", 32'(te1), 32'd0);
    chk("midrun_rst_busy", 32'(busy1), 32'd0);
    chk("midrun_rst_done", 32'(done1), 32'd0);
    chk("midrun_rst_response", 32'(resp1), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    cp_cnt1 = 0;
    repeat (10) @(negedge sys_clk);
    chk("midrun_rst_no_cp", 32'(cp_cnt1), 32'd0);
    chk("midrun_rst_chain_kept", 32'(chain1), 32'(snap));

    // rst and start together: rst wins
    d0 = done_cnt1;
    @(negedge sys_clk);
    rst = 1'b1; start1 = 1'b1; cap1 = 1'b1; pat1 = 8'hFF;
    @(negedge sys_clk);
    rst = 1'b0; start1 = 1'b0;
    chk("rst_start_busy_now", 32'(busy1), 32'd0);
    repeat (4) @(negedge sys_clk);
    chk("rst_start_busy_later", 32'(busy1), 32'd0);
    chk("rst_start_no_done", 32'(done_cnt1 - d0), 32'd0);

    // Minimum-length chain with a 3-cycle divider
    run2(1'b1, 2'b10, 2'b01, 2'b00, 17);
    run2(1'b0, 2'b11, 2'b01, 2'b11, 8);

    repeat (3) @(negedge sys_clk);
    chk("dut1_scoreboard_drained", 32'(q1.size()), 32'd0);
    chk("dut2_scoreboard_drained", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
